microseq_next_state: RTL
========================

Name: microseq_next_state

Overview:
- Control-unit microsequencer, directly downstream of the instruction encoder.
- Holds the current microstate register. Each cycle it selects the next microstate from one of these sources:
  - the encoder's 8-bit decode state
  - an incrementer
  - the microinstruction's next-address field
  - a small micro-return stack
- Registered state output drives the microstore address. Next-state control bits come back from the control register.

Parameters:
- SW, 8, microstate width; must match encoder output width.
- DEPTH, 4, micro-return stack entries (power of 2, ≥2).
- RESET_STATE, 0, state loaded on reset; equals the encoder's idle code for IR==0.
- FETCH_STATE, 1, first state of the instruction-fetch microroutine.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enc_state  in  SW  decode state from the encoder, combinational from IR.
- cr_addr  in  SW  next-address field of the current microinstruction.
- ns_ctrl  in  3  next-state control field of the current microinstruction.
- inv  in  1  inverts the condition/moc sense for CJMP and WAIT.
- cond  in  1  condition-tester result, valid in the same cycle.
- moc  in  1  memory-operation-complete from the memory interface.
- state  out  SW  current microstate, registered.
- moc_wait  out  1  combinational; high while in WAIT and the effective moc is 0.
- stk_depth  out  clog2(DEPTH)+1  current stack occupancy.
- stk_err  out  1  sticky over/underflow flag.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=RESET_STATE, stack pointer=0, stk_err=0.
  - Stack contents are don't-care.
  - Reset released mid-routine restarts from RESET_STATE. No partial stack state survives.
- Update rule:
  - All updates occur on the rising edge of clk while reset_n=1.
  - Next state is a combinational function of the current inputs. Latency is one cycle from ns_ctrl to state.
  - inc = state+1 modulo 2^SW, so 255 wraps to 0 with no flag.
  - eff = (ns_ctrl==WAIT ? moc : cond) XOR inv.
- ns_ctrl decode:
  - 0 DEC: state<=enc_state.
  - 1 INC: state<=inc.
  - 2 JMP: state<=cr_addr.
  - 3 CJMP: state<= eff ? cr_addr : inc.
  - 4 WAIT: state<= eff ? inc : state (hold). moc_wait=~eff. A hold has no cycle limit.
  - 5 CALL: push inc; state<=cr_addr; depth+1.
  - 6 RET: pop top; state<=popped value; depth-1.
  - 7 FETCH: state<=FETCH_STATE.
- Stack:
  - LIFO.
  - CALL when depth==DEPTH: jump still taken, push discarded, depth unchanged, stk_err<=1.
  - RET when depth==0: state<=FETCH_STATE, depth stays 0, stk_err<=1.
  - stk_err clears only on reset.
  - Push and pop never occur in the same cycle, since a cycle carries only one ns_ctrl.
- moc_wait is 0 for every ns_ctrl other than WAIT.
- Unknown or X on ns_ctrl: no special handling. All 8 codes are defined.

Decomposition:
- Shared package cu_pkg:
  - ns_ctrl localparams NS_DEC..NS_FETCH (0..7).
  - SW default.
  - RESET_STATE and FETCH_STATE constants, shared with the encoder and microstore.
- Sub-module micro_ret_stack:
  - Parameters DEPTH and SW.
  - Inputs push, pop, din.
  - Outputs dout, depth, full, empty.
  - Uses the same clk and reset_n.
  - The top level holds the state register, the mux, and the error flag.

Test Plan:
1. Reset and decode:
   - Stimulus: assert reset_n=0 mid-cycle, then release.
   - Required: state=0 immediately (async), stk_err=0, depth=0.
   - Stimulus: ns_ctrl=DEC, enc_state=10.
   - Required: state=10 after one edge.
2. Increment, conditional jump, wrap:
   - Stimulus: from state=254, INC twice.
   - Required: 255, then 0.
   - Stimulus: CJMP with cr_addr=44, cond=1, inv=0.
   - Required: 44.
   - Stimulus: same with inv=1.
   - Required: state+1.
3. Memory wait:
   - Stimulus: WAIT with moc=0 for 3 cycles.
   - Required: state unchanged, moc_wait=1 each cycle.
   - Stimulus: moc=1.
   - Required: state+1 next edge, moc_wait=0.
   - Stimulus: repeat with inv=1 and moc held at 1.
   - Required: holds.
4. Call/return nesting:
   - Stimulus: CALL at states 20, 30 and 40 with cr_addr=30, 40 and 50 respectively.
   - Required: depth=3.
   - Stimulus: RET three times.
   - Required: states 41, 31, 21; depth=0; stk_err=0.
5. Overflow/underflow:
   - Stimulus: DEPTH+1 CALLs.
   - Required: last jump taken, depth=DEPTH, stk_err=1.
   - Stimulus: after a reset, RET on an empty stack.
   - Required: state=FETCH_STATE=1, stk_err=1, sticky until reset_n=0.
6. Fetch loop:
   - Stimulus: FETCH, then INC×2, then DEC with enc_state=31 (load-multiple).
   - Required: states 1, 2, 3, 31.

Source files
------------

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - control-unit shared constants: next-state codes and state defaults
package cu_pkg;

  localparam int CU_SW          = 8;
  localparam int CU_RESET_STATE = 0;
  localparam int CU_FETCH_STATE = 1;

  localparam logic [2:0] NS_DEC   = 3'd0;
  localparam logic [2:0] NS_INC   = 3'd1;
  localparam logic [2:0] NS_JMP   = 3'd2;
  localparam logic [2:0] NS_CJMP  = 3'd3;
  localparam logic [2:0] NS_WAIT  = 3'd4;
  localparam logic [2:0] NS_CALL  = 3'd5;
  localparam logic [2:0] NS_RET   = 3'd6;
  localparam logic [2:0] NS_FETCH = 3'd7;

endpackage

// File: rtl/micro_ret_stack.sv
// rtl/micro_ret_stack.sv - LIFO micro-return stack; only the pointer is reset
module micro_ret_stack #(
  parameter int DEPTH = 4,
  parameter int SW    = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [SW-1:0]              din,
  output logic [SW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SW-1:0] mem [DEPTH];
  logic [AW:0]   ptr;
  logic [AW:0]   ptr_m1;

  assign ptr_m1 = ptr - 1'b1;
  assign full   = (ptr == (AW+1)'(DEPTH));
  assign empty  = (ptr == '0);
  assign depth  = ptr;
  assign dout   = mem[ptr_m1[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/microseq_next_state.sv
// rtl/microseq_next_state.sv - microsequencer: state register, next-state mux, stack error flag
module microseq_next_state
  import cu_pkg::*;
#(
  parameter int SW          = CU_SW,
  parameter int DEPTH       = 4,
  parameter int RESET_STATE = CU_RESET_STATE,
  parameter int FETCH_STATE = CU_FETCH_STATE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SW-1:0]          enc_state,
  input  logic [SW-1:0]          cr_addr,
  input  logic [2:0]             ns_ctrl,
  input  logic                   inv,
  input  logic                   cond,
  input  logic                   moc,
  output logic [SW-1:0]          state,
  output logic                   moc_wait,
  output logic [$clog2(DEPTH):0] stk_depth,
  output logic                   stk_err
);

  localparam logic [SW-1:0] RST_V   = SW'(RESET_STATE);
  localparam logic [SW-1:0] FETCH_V = SW'(FETCH_STATE);

  logic [SW-1:0] inc;
  logic [SW-1:0] nxt;
  logic [SW-1:0] stk_dout;
  logic          eff;
  logic          push;
  logic          pop;
  logic          err_set;
  logic          stk_full;
  logic          stk_empty;

  micro_ret_stack #(.DEPTH(DEPTH), .SW(SW)) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (inc),
    .dout    (stk_dout),
    .depth   (stk_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  assign inc = state + SW'(1);
  assign eff = ((ns_ctrl == NS_WAIT) ? moc : cond) ^ inv;

  always_comb begin
    nxt      = state;
    push     = 1'b0;
    pop      = 1'b0;
    err_set  = 1'b0;
    moc_wait = 1'b0;
    case (ns_ctrl)
      NS_DEC:  nxt = enc_state;
      NS_INC:  nxt = inc;
      NS_JMP:  nxt = cr_addr;
      NS_CJMP: nxt = eff ? cr_addr : inc;
      NS_WAIT: begin
        nxt      = eff ? inc : state;
        moc_wait = ~eff;
      end
      // Overflowing CALL still jumps; only the return address is lost.
      NS_CALL: begin
        nxt = cr_addr;
        if (stk_full) err_set = 1'b1;
        else          push    = 1'b1;
      end
      NS_RET: begin
        if (stk_empty) begin
          nxt     = FETCH_V;
          err_set = 1'b1;
        end else begin
          nxt = stk_dout;
          pop = 1'b1;
        end
      end
      default: nxt = FETCH_V;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RST_V;
      stk_err <= 1'b0;
    end else begin
      state <= nxt;
      if (err_set) stk_err <= 1'b1;
    end
  end

endmodule
